// File: rtl/sseg_mux_driver.sv
// Multiplexed seven-segment display driver.
// Walks NUM_DIGITS digits in turn: each digit gets an all-off dead time of
// BLANK_CYC cycles followed by DRIVE_CYC cycles with its anode enabled.
// Display data is double buffered (pending -> active at frame wrap) so a
// frame never shows a mix of two loads.
// Optional feature macro: SSEG_LEAD_ZERO_BLANK_EN (suppress leading zeros).
module sseg_mux_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DRIVE_CYC  = 100000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              sseg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CNT_MAX = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int PTR_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PTR_W-1:0]        ptr_q;

    logic [4*NUM_DIGITS-1:0] pend_hex_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q;
    logic [4*NUM_DIGITS-1:0] act_hex_q;
    logic [NUM_DIGITS-1:0]   act_dp_q;
    logic [NUM_DIGITS-1:0]   act_blank_q;

    logic [6:0]              sseg_q;
    logic                    dp_n_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_start_q;

    logic [NUM_DIGITS-1:0]   lz_dark_d;
    logic [3:0]              cur_hex_d;
    logic                    cur_dp_d;
    logic                    cur_dark_d;
    logic [6:0]              glyph_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    last_cnt_blank_d;
    logic                    last_cnt_drive_d;
    logic                    last_ptr_d;

    // Active-low glyph for one hex nibble, segment order abcdefg (bit 6 = a).
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Leading-zero suppression: digit k>0 goes dark when it and every digit
    // above it hold zero. Digit 0 always shows, so a zero value reads "0".
    genvar gi;
`ifdef SSEG_LEAD_ZERO_BLANK_EN
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lsd
                assign lz_dark_d[gi] = 1'b0;
            end else begin : g_upper
                assign lz_dark_d[gi] = ~|act_hex_q[4*NUM_DIGITS-1:4*gi];
            end
        end
    endgenerate
`else
    assign lz_dark_d = '0;
`endif

    // Decode what the currently selected digit should put on the pins.
    always_comb begin
        cur_hex_d        = act_hex_q[{ptr_q, 2'b00} +: 4];
        cur_dp_d         = act_dp_q[ptr_q];
        cur_dark_d       = act_blank_q[ptr_q] | lz_dark_d[ptr_q];
        glyph_d          = hex_glyph(cur_hex_d);
        an_d             = ~(NUM_DIGITS'(1) << ptr_q);
        last_cnt_blank_d = (cnt_q == CNT_W'(BLANK_CYC - 1));
        last_cnt_drive_d = (cnt_q == CNT_W'(DRIVE_CYC - 1));
        last_ptr_d       = (ptr_q == PTR_W'(NUM_DIGITS - 1));
    end

    // Scan FSM, data buffers and registered pin drivers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            ptr_q         <= '0;
            pend_hex_q    <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            act_hex_q     <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            an_q          <= '1;
            sseg_q        <= '1;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            if (load) begin
                pend_hex_q   <= hex_in;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank_in;
            end
            case (state_q)
                ST_BLANK: begin
                    an_q          <= '1;
                    sseg_q        <= '1;
                    dp_n_q        <= 1'b1;
                    frame_start_q <= 1'b0;
                    if (last_cnt_blank_d) begin
                        state_q <= ST_DRIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    an_q          <= an_d;
                    sseg_q        <= cur_dark_d ? 7'h7F : glyph_d;
                    dp_n_q        <= cur_dark_d | ~cur_dp_d;
                    frame_start_q <= (ptr_q == '0) && (cnt_q == '0);
                    if (last_cnt_drive_d) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        if (last_ptr_d) begin
                            // Frame wrap: a coincident load bypasses the pending buffer.
                            ptr_q       <= '0;
                            act_hex_q   <= load ? hex_in   : pend_hex_q;
                            act_dp_q    <= load ? dp_in    : pend_dp_q;
                            act_blank_q <= load ? blank_in : pend_blank_q;
                        end else begin
                            ptr_q <= ptr_q + PTR_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign sseg        = sseg_q;
    assign dp_n        = dp_n_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver with NUM_DIGITS=4, DRIVE_CYC=4, BLANK_CYC=1.
// One frame is 20 cycles: per digit one dark cycle then four driven cycles.
module tb_sseg_mux_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic [6:0]  sseg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_start;

    int n_cmp = 0;
    int n_err = 0;

    sseg_mux_driver #(
        .NUM_DIGITS(4),
        .DRIVE_CYC (4),
        .BLANK_CYC (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .sseg       (sseg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-entered glyph table.
    function automatic logic [6:0] exp_glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Expected leading-zero darkness of digit k for a frame value.
    function automatic logic exp_lz(input logic [15:0] v, input int k);
`ifdef SSEG_LEAD_ZERO_BLANK_EN
        logic [15:0] above;
        above = v >> (4 * k);
        return (k > 0) && (above == 16'h0);
`else
        return (v[0] & 1'b0) | (k < 0);
`endif
    endfunction

    // Checks one whole frame starting at its first drive sample (s=0) and
    // ends on the next frame's first drive sample. Up to two loads are
    // issued after the samples given by ld_step / ld2_step.
    task automatic run_frame(input string name,
                             input logic [15:0] e_hex, input logic [3:0] e_dp,
                             input logic [3:0] e_blank,
                             input int ld_step, input logic [15:0] l_hex,
                             input logic [3:0] l_dp, input logic [3:0] l_blank,
                             input int ld2_step, input logic [15:0] l2_hex,
                             input logic [3:0] l2_dp, input logic [3:0] l2_blank);
        for (int s = 0; s < 20; s++) begin
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dpn;
            logic       dark;
            int         k;
            k = s / 5;
            if ((s % 5) == 4) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dpn = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << k);
                dark  = e_blank[k] | exp_lz(e_hex, k);
                e_seg = dark ? 7'h7F : exp_glyph(e_hex[4*k +: 4]);
                e_dpn = dark | ~e_dp[k];
            end
            chk($sformatf("%s.s%0d.an", name, s), 32'(an), 32'(e_an));
            chk($sformatf("%s.s%0d.sseg", name, s), 32'(sseg), 32'(e_seg));
            chk($sformatf("%s.s%0d.dp_n", name, s), 32'(dp_n), 32'(e_dpn));
            chk($sformatf("%s.s%0d.fs", name, s), 32'(frame_start), 32'(s == 0));
            if (s == ld_step) begin
                load = 1'b1; hex_in = l_hex; dp_in = l_dp; blank_in = l_blank;
            end else if (s == ld2_step) begin
                load = 1'b1; hex_in = l2_hex; dp_in = l2_dp; blank_in = l2_blank;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        int          fs_cnt;
        int          frames_done;
        int          viol_hot;
        int          viol_move;
        logic [3:0]  prev_an;

        // Reset held for three edges.
        reset_n = 1'b0;
        tick(); tick(); tick();
        chk("rst.an", 32'(an), 32'hF);
        chk("rst.sseg", 32'(sseg), 32'h7F);
        chk("rst.dp_n", 32'(dp_n), 32'h1);
        chk("rst.fs", 32'(frame_start), 32'h0);

        // One edge after release the outputs still show the dead time.
        reset_n = 1'b1;
        tick();
        chk("rel1.an", 32'(an), 32'hF);
        chk("rel1.fs", 32'(frame_start), 32'h0);
        tick();

        // A: reset-cleared buffers show zeros; load 12AF mid-frame.
        run_frame("A", 16'h0000, 4'b0000, 4'b0000,
                  5, 16'h12AF, 4'b0100, 4'b0000, -1, 16'h0, 4'h0, 4'h0);
        // B: 12AF with dp on the digit showing 2; load zeros on the wrap cycle.
        run_frame("B", 16'h12AF, 4'b0100, 4'b0000,
                  17, 16'h0000, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0);
        // C: zeros; 8888 loaded mid-frame must not leak into this frame.
        run_frame("C", 16'h0000, 4'b0000, 4'b0000,
                  7, 16'h8888, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0);
        // D: 8888; load 5555 on the wrap cycle.
        run_frame("D", 16'h8888, 4'b0000, 4'b0000,
                  17, 16'h5555, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0);
        // E: 5555 straight from the wrap load; two loads, the last one wins.
        run_frame("E", 16'h5555, 4'b0000, 4'b0000,
                  3, 16'h9999, 4'b1111, 4'b1111, 12, 16'h0007, 4'b0001, 4'b0000);
        // F: 0007 (leading zeros depend on the build); load with force-blank.
        run_frame("F", 16'h0007, 4'b0001, 4'b0000,
                  10, 16'h5555, 4'b1111, 4'b0100, -1, 16'h0, 4'h0, 4'h0);
        // G: digit 2 forced dark while its anode stays enabled.
        run_frame("G", 16'h5555, 4'b1111, 4'b0100,
                  -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

        // Reset in the middle of driving digit 0.
        tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("mid.an", 32'(an), 32'hF);
        chk("mid.sseg", 32'(sseg), 32'h7F);
        chk("mid.dp_n", 32'(dp_n), 32'h1);
        chk("mid.fs", 32'(frame_start), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("mid.rel.an", 32'(an), 32'hF);
        tick();
        // H: restart from digit 0 with both buffers cleared.
        run_frame("H", 16'h0000, 4'b0000, 4'b0000,
                  -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

        // Random loads over 10000 cycles (exactly 500 frames from here).
        fs_cnt      = 0;
        frames_done = 0;
        viol_hot    = 0;
        viol_move   = 0;
        prev_an     = 4'hF;
        for (int i = 0; i < 10000; i++) begin
            if (frame_start === 1'b1) fs_cnt++;
            if (prev_an[3] === 1'b0 && an[3] === 1'b1) frames_done++;
            if (an !== 4'hF && $countones(~an) != 1) viol_hot++;
            if (prev_an !== 4'hF && an !== 4'hF && an !== prev_an) viol_move++;
            prev_an  = an;
            load     = ($urandom_range(0, 7) == 0);
            hex_in   = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom);
            tick();
        end
        load = 1'b0;
        chk("rand.onehot", 32'(viol_hot), 32'd0);
        chk("rand.move", 32'(viol_move), 32'd0);
        chk("rand.frames", 32'(frames_done), 32'd500);
        chk("rand.fs_cnt", 32'(fs_cnt), 32'(frames_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sseg_mux_driver.md
SSEG_MUX_DRIVER -- requirements
Module: sseg_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DRIVE_CYC, default 100000, clock cycles each digit is driven; legal minimum 2.
REQ-003 Parameter BLANK_CYC, default 16, all-off dead-time cycles before each digit; legal minimum 1.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 hex_in  in  4*NUM_DIGITS  digit values; digit k is bits [4k+3:4k]; digit 0 is the least significant.
REQ-007 dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 blank_in  in  NUM_DIGITS  force-blank per digit, 1 = dark.
REQ-009 load  in  1  single-cycle strobe that captures hex_in, dp_in and blank_in into the pending buffer.
REQ-010 sseg  out  7  segments abcdefg (bit 6 = a), active-low, registered.
REQ-011 dp_n  out  1  decimal point, active-low, registered.
REQ-012 an  out  NUM_DIGITS  digit enables, active-low, one-hot or all-high, registered.
REQ-013 frame_start  out  1  one-cycle pulse on the first drive cycle of digit 0.

Function
REQ-014 The FSM SHALL have two states, BLANK and DRIVE, driven by a cycle counter and a digit pointer ptr.
- BLANK: an, sseg and dp_n all high for BLANK_CYC cycles, then go to DRIVE.
- DRIVE: an[ptr] low for DRIVE_CYC cycles, then go to BLANK with ptr+1, wrapping from NUM_DIGITS-1 to 0.
REQ-015 The glyph decode SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-016 During DRIVE, sseg SHALL be the glyph of active digit ptr, and dp_n SHALL be the inverse of active dp[ptr].
REQ-017 A digit whose active blank bit is set SHALL drive sseg=1111111 and dp_n=1 while an[ptr] stays low.
REQ-018 On each cycle with load high, the pending buffer SHALL capture the inputs, the last capture winning.
REQ-019 The pending buffer SHALL copy to the active buffer on the cycle ptr wraps to 0, so a frame never mixes two loads.
REQ-020 If load coincides with the wrap cycle, the loaded values SHALL go directly to the active buffer.
REQ-021 Outputs SHALL be registered, with one cycle of latency from the state or counter decision to the pins.
REQ-022 No cycle SHALL have more than one an bit low, and an SHALL never move between two digits without at least BLANK_CYC all-high cycles.
REQ-023 frame_start SHALL assert exactly once per frame, in the same cycle an[0] first goes low.

Reset
REQ-024 With reset_n low at a clock edge, the block SHALL enter BLANK with counter=0 and ptr=0.
REQ-025 Reset SHALL clear the pending and active buffers to zero, set an to all ones, sseg to 1111111 and dp_n to 1, and clear frame_start.
REQ-026 Reset asserted mid-DRIVE SHALL force all outputs dark on the next edge, and the sequence SHALL restart from digit 0 with a full BLANK period.

Configuration
REQ-027 With SSEG_LEAD_ZERO_BLANK_EN defined, a digit k>0 SHALL be dark when its value and the values of all digits above it are zero; digit 0 is never suppressed by this rule.
REQ-028 Without SSEG_LEAD_ZERO_BLANK_EN, every digit SHALL display its glyph, subject only to blank_in.

Verification
All scenarios run with NUM_DIGITS=4, DRIVE_CYC=4, BLANK_CYC=1.
REQ-029 Reset held 3 cycles, then released -> an=1111, sseg=1111111, dp_n=1; the first an=1110 appears 2 cycles after release; frame_start pulses with it.
REQ-030 load with hex_in=16'h12AF, dp_in=0100 -> the next frame shows F, A, 2, 1 on an 1110, 1101, 1011, 0111 respectively; dp_n=0 only for the digit showing 2; each digit is driven 4 cycles, separated by 1 all-off cycle.
REQ-031 load of 16'h8888 in mid-frame of 16'h0000 -> the remaining digits of that frame still show 0 (0000001); 8 (0000000) appears only from the next frame_start.
REQ-032 load asserted on the wrap cycle with 16'h5555 -> the immediately following frame shows 5 (0100100) on all digits.
REQ-033 hex_in=16'h0007, macro defined -> digits 3..1 are dark and digit 0 shows 0001111; macro undefined -> digits 3..1 show 0000001.
REQ-034 Random loads over 10000 cycles -> an is never more than one-hot, an never changes one-hot directly to a different one-hot, and frame_start count equals the number of completed frames.
